// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = x - y - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             br_next;

   // Full-subtractor cell on the current LSBs.
   assign d_bit   = a_sh[0] ^ b_sh[0] ^ br;
   assign br_next = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);

`ifdef SERIAL_SUB_OVF_EN
   logic x_msb;
   logic y_msb;
`endif

   // NOTE: every register here is written with <= so all updates take the
   // values sampled at the same edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         x_msb <= 1'b0;
         y_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= x;
                  b_sh  <= y;
                  br    <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  x_msb <= x[WIDTH-1];
                  y_msb <= y[WIDTH-1];
`endif
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_next;
               // Result enters at the MSB so bit 0 lands in diff[0] after WIDTH steps.
               diff <= {d_bit, diff[WIDTH-1:1]};
               if (cnt == CW'(WIDTH - 1)) begin
                  bout  <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf   <= (x_msb != y_msb) && (d_bit != x_msb);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only in IDLE or DONE.
REQ-005 SHALL have port x  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 SHALL have port y  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 SHALL have port bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result (DONE state).
REQ-010 SHALL have port diff  output  WIDTH  result, x - y - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out, 1 when x < y + bin (unsigned).

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE, all registered.
REQ-013 SHALL, in IDLE or DONE with start=1, latch x, y and bin into internal shift and borrow registers, clear the bit counter and enter SHIFT.
REQ-014 SHALL, in each SHIFT cycle, process one bit, LSB first: d = a^b^br and br' = (~a&b)|(~a&br)|(b&br), where a and b are the current LSBs of the shifted operands.
REQ-015 SHALL shift each d into the MSB of the result register and shift the result right by one, so diff[0] holds bit 0 after WIDTH steps.
REQ-016 SHALL move from SHIFT to DONE on the edge that processes bit WIDTH-1; the counter is log2-sized and SHALL NOT wrap past WIDTH-1.
REQ-017 SHALL have a latency of WIDTH edges: done is high in the cycle after edge E0+WIDTH, where E0 is the accepting edge.
REQ-018 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE, or go to SHIFT if start=1 (back-to-back operation).
REQ-019 SHALL hold diff and bout stable from DONE until the next accepting edge; diff is undefined-to-observers while busy=1.
REQ-020 SHALL ignore start while in SHIFT; the in-flight operation continues unchanged.
REQ-021 SHALL keep busy and done mutually exclusive; both are 0 in IDLE.

Reset
REQ-022 SHALL, with rst=1 at an edge, force IDLE and set busy=0, done=0, diff=0, bout=0, counter=0, and clear all shift registers.
REQ-023 SHALL, on reset during SHIFT, abort the operation with no done pulse.
REQ-024 SHALL give rst priority over start on the same edge.

Configuration
REQ-025 SHALL, when macro SERIAL_SUB_OVF_EN is defined, add port ovf  output  1, the two's-complement overflow of the signed result.
REQ-026 SHALL compute ovf as (x[MSB] != y[MSB]) && (diff[MSB] != x[MSB]); it is valid and held under the same rules as diff, and reset to 0.
REQ-027 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no ovf port and no associated logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: WIDTH=4, x=5, y=3, bin=0, start at E0 -> busy high through E4, done high one cycle after E4, diff=2, bout=0.
REQ-029 SHALL cover: x=3, y=5, bin=0 -> diff=4'b1110 (14), bout=1.
REQ-030 SHALL cover: x=0, y=0, bin=1 -> diff=15, bout=1; then start=1 in the DONE cycle with x=9, y=4, bin=0 -> no IDLE gap, diff=5, bout=0 at E+4.
REQ-031 SHALL cover: start=1 with new operands during SHIFT -> ignored; result matches the first operands, single done pulse.
REQ-032 SHALL cover: rst=1 at E2 of an operation -> done is never asserted, and all outputs are 0 on the next cycle.
REQ-033 SHALL cover, with SERIAL_SUB_OVF_EN defined: x=4'b0111, y=4'b1000, bin=0 -> diff=4'b1111, ovf=1; and x=5, y=3 -> ovf=0.
